// File: rtl/dds_pkg.sv
// Shared types and default widths for the dds core and its sweep controller.
package dds_pkg;

  localparam int FW_DEF = 8;
  localparam int PW_DEF = 8;

  typedef enum logic {IDLE, RUN} state_e;
  typedef enum logic {UP, DOWN}  dir_e;

endpackage

// File: rtl/dds_dwell_timer.sv
// Dwell counter: counts while enabled, terminal count when it reaches dwell, then wraps to 0.
module dds_dwell_timer #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] dwell,
  output logic          tc
);

  logic [DW-1:0] cnt;

  assign tc = en && (cnt == dwell);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)            cnt <= '0;
    else if (clr || tc)   cnt <= '0;
    else if (en)          cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer driving the dds control word inputs (f_word, p_word, sel, amp, ena).
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int FW = FW_DEF,
  parameter int PW = PW_DEF,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic          abort,
  input  logic          loop_mode,
  input  logic [FW-1:0] cfg_f_start,
  input  logic [FW-1:0] cfg_f_stop,
  input  logic [FW-1:0] cfg_f_step,
  input  logic [DW-1:0] cfg_dwell,
  input  logic [PW-1:0] cfg_p_word,
  input  logic [1:0]    cfg_sel,
  input  logic [1:0]    cfg_amp,
  output logic          wave_ena,
  output logic [1:0]    wave_sel,
  output logic [1:0]    wave_amp,
  output logic [FW-1:0] f_word,
  output logic [PW-1:0] p_word,
  output logic          busy,
  output logic          done,
  output logic          step_tick
);

  typedef struct packed {
    logic [FW-1:0] f_start;
    logic [FW-1:0] f_stop;
    logic [FW-1:0] f_step;
    logic [DW-1:0] dwell;
    logic          loop;
    dir_e          dir;
  } cfg_t;

  state_e        state_q, state_d;
  cfg_t          cfg_q, cfg_d;
  logic          ena_d, busy_d, done_d, tick_d;
  logic [1:0]    sel_d, amp_d;
  logic [FW-1:0] f_d;
  logic [PW-1:0] p_d;
  logic          tmr_clr, tmr_en, tmr_tc;

  logic [FW-1:0] step_eff;
  logic [FW:0]   nxt_up, nxt_dn;
  logic          clamp_up, clamp_dn;

  dds_dwell_timer #(.DW(DW)) u_dwell (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .dwell (cfg_q.dwell),
    .tc    (tmr_tc)
  );

  // Next word carries one extra bit so overflow/underflow clamps to f_stop instead of wrapping.
  assign step_eff = (cfg_q.f_step == '0) ? {{(FW-1){1'b0}}, 1'b1} : cfg_q.f_step;
  assign nxt_up   = {1'b0, f_word} + {1'b0, step_eff};
  assign nxt_dn   = {1'b0, f_word} - {1'b0, step_eff};
  assign clamp_up = nxt_up >= {1'b0, cfg_q.f_stop};
  assign clamp_dn = nxt_dn[FW] || (nxt_dn[FW-1:0] <= cfg_q.f_stop);

  assign tmr_en  = (state_q == RUN) && !abort;
  assign tmr_clr = !tmr_en;

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    ena_d   = wave_ena;
    busy_d  = busy;
    sel_d   = wave_sel;
    amp_d   = wave_amp;
    f_d     = f_word;
    p_d     = p_word;
    done_d  = 1'b0;
    tick_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d       = RUN;
          cfg_d.f_start = cfg_f_start;
          cfg_d.f_stop  = cfg_f_stop;
          cfg_d.f_step  = cfg_f_step;
          cfg_d.dwell   = cfg_dwell;
          cfg_d.loop    = loop_mode;
          cfg_d.dir     = (cfg_f_start <= cfg_f_stop) ? UP : DOWN;
          ena_d         = 1'b1;
          busy_d        = 1'b1;
          f_d           = cfg_f_start;
          p_d           = cfg_p_word;
          sel_d         = cfg_sel;
          amp_d         = cfg_amp;
        end
      end
      RUN: begin
        if (abort || (tmr_tc && f_word == cfg_q.f_stop && !cfg_q.loop)) begin
          state_d = IDLE;
          ena_d   = 1'b0;
          busy_d  = 1'b0;
          sel_d   = '0;
          amp_d   = '0;
          f_d     = '0;
          p_d     = '0;
          done_d  = !abort;
        end else if (tmr_tc) begin
          tick_d = 1'b1;
          if (f_word == cfg_q.f_stop)
            f_d = cfg_q.f_start;
          else if (cfg_q.dir == UP)
            f_d = clamp_up ? cfg_q.f_stop : nxt_up[FW-1:0];
          else
            f_d = clamp_dn ? cfg_q.f_stop : nxt_dn[FW-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cfg_q     <= '0;
      wave_ena  <= 1'b0;
      busy      <= 1'b0;
      wave_sel  <= '0;
      wave_amp  <= '0;
      f_word    <= '0;
      p_word    <= '0;
      done      <= 1'b0;
      step_tick <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      wave_ena  <= ena_d;
      busy      <= busy_d;
      wave_sel  <= sel_d;
      wave_amp  <= amp_d;
      f_word    <= f_d;
      p_word    <= p_d;
      done      <= done_d;
      step_tick <= tick_d;
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: sweeps are expanded into per-cycle expected outputs.
module tb_dds_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start, abort, loop_mode;
  logic [7:0] cfg_f_start, cfg_f_stop, cfg_f_step, cfg_p_word;
  logic [15:0] cfg_dwell;
  logic [1:0] cfg_sel, cfg_amp;
  logic       wave_ena, busy, done, step_tick;
  logic [1:0] wave_sel, wave_amp;
  logic [7:0] f_word, p_word;

  typedef struct packed {
    logic       ena, bsy, dn, tick;
    logic [1:0] sel, amp;
    logic [7:0] f, p;
  } rec_t;

  rec_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_on = 0;

  always #5 clk = ~clk;

  dds_sweep_ctrl #(.FW(8), .PW(8), .DW(16)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort), .loop_mode(loop_mode),
    .cfg_f_start(cfg_f_start), .cfg_f_stop(cfg_f_stop), .cfg_f_step(cfg_f_step),
    .cfg_dwell(cfg_dwell), .cfg_p_word(cfg_p_word), .cfg_sel(cfg_sel), .cfg_amp(cfg_amp),
    .wave_ena(wave_ena), .wave_sel(wave_sel), .wave_amp(wave_amp), .f_word(f_word),
    .p_word(p_word), .busy(busy), .done(done), .step_tick(step_tick)
  );

  function automatic rec_t actual();
    rec_t a;
    a.ena = wave_ena; a.bsy = busy; a.dn = done; a.tick = step_tick;
    a.sel = wave_sel; a.amp = wave_amp; a.f = f_word; a.p = p_word;
    return a;
  endfunction

  // Monitor: any active output must match the head of the expected queue.
  always begin
    rec_t a, e;
    @(posedge clk); #1;
    if (mon_on) begin
      a = actual();
      checks++;
      if (a.ena || a.bsy || a.dn || a.tick) begin
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output act=%h exp=none t=%0t", a, $time);
        end else begin
          e = q.pop_front();
          if (a !== e) begin
            errors++;
            $display("FAIL scoreboard act=%h exp=%h t=%0t", a, e, $time);
          end
        end
      end else if (a !== '0) begin
        errors++;
        $display("FAIL idle_zero act=%h exp=0 t=%0t", a, $time);
      end
    end
  end

  // Reference: list of frequencies from the sweep rules, each held dw+1 cycles.
  task automatic push_sweep(input int fs, input int fe, input int st, input int dw, input bit lp,
                            input logic [1:0] sel, input logic [1:0] amp, input logic [7:0] p,
                            input int maxrec, output int n);
    int cur; bit first; bit up; rec_t r;
    if (st == 0) st = 1;
    up = (fs <= fe); cur = fs; first = 1; n = 0;
    while (n < maxrec) begin
      for (int d = 0; d <= dw && n < maxrec; d++) begin
        r = '0; r.ena = 1; r.bsy = 1; r.sel = sel; r.amp = amp; r.p = p;
        r.f = cur[7:0]; r.tick = (d == 0) && !first;
        q.push_back(r); n++; first = 0;
      end
      if (n >= maxrec) break;
      if (cur == fe) begin
        if (lp) cur = fs;
        else begin r = '0; r.dn = 1; q.push_back(r); n++; break; end
      end else if (up) cur = (cur + st > fe) ? fe : cur + st;
      else             cur = (cur - st < fe) ? fe : cur - st;
    end
  endtask

  task automatic scramble_cfg();
    cfg_f_start = 8'($urandom); cfg_f_stop = 8'($urandom); cfg_f_step = 8'($urandom);
    cfg_dwell = 16'($urandom_range(0, 3)); cfg_p_word = 8'($urandom);
    cfg_sel = 2'($urandom); cfg_amp = 2'($urandom); loop_mode = 1'($urandom);
  endtask

  task automatic drain(input string name);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_%s act=%0d exp=0 pending", name, q.size());
      q.delete();
    end
  endtask

  // ab>0: abort sampled on the edge after ab output records; ms: start pulse mid-sweep.
  task automatic sweep(input int fs, input int fe, input int st, input int dw, input bit lp,
                       input int ab, input bit ms);
    int n;
    @(negedge clk);
    cfg_f_start = 8'(fs); cfg_f_stop = 8'(fe); cfg_f_step = 8'(st); cfg_dwell = 16'(dw);
    cfg_p_word = 8'($urandom); cfg_sel = 2'($urandom); cfg_amp = 2'($urandom);
    loop_mode = lp; start = 1;
    push_sweep(fs, fe, st, dw, lp, cfg_sel, cfg_amp, cfg_p_word, (ab > 0) ? ab : 32'h4000_0000, n);
    @(negedge clk);
    start = 0;
    scramble_cfg();
    if (ab > 0) begin
      repeat (ab - 1) @(negedge clk);
      abort = 1;
      @(negedge clk);
      abort = 0;
      repeat (3) @(negedge clk);
    end else begin
      for (int c = 1; c <= n + 3; c++) begin
        start = (ms && c == 1 && n > 4);
        @(negedge clk);
      end
      start = 0;
    end
    drain("sweep");
  endtask

  initial begin
    #(10 * 90000);
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rec_t a;
    int fs, fe, st, dw, ab;
    bit lp;
    rstn = 0; start = 0; abort = 0;
    scramble_cfg();
    repeat (3) @(negedge clk);
    start = 1;
    @(negedge clk);
    a = actual();
    checks++;
    if (a !== '0) begin errors++; $display("FAIL reset_outputs act=%h exp=0", a); end
    start = 0;
    rstn = 1;
    mon_on = 1;
    repeat (2) @(negedge clk);

    sweep(10, 40, 10, 2, 0, 0, 0);    // 10,20,30,40 x3 then done
    sweep(50, 5, 20, 0, 0, 0, 0);     // down with clamp
    sweep(200, 255, 100, 1, 0, 0, 0); // overflow clamp
    sweep(250, 3, 7, 0, 0, 0, 0);     // underflow clamp
    sweep(0, 2, 1, 0, 1, 12, 0);      // loop mode, aborted
    sweep(10, 40, 10, 2, 0, 4, 0);    // abort in second dwell
    sweep(10, 40, 10, 2, 0, 0, 1);    // start while busy ignored
    sweep(3, 5, 0, 0, 0, 0, 0);       // step 0 acts as 1
    sweep(77, 77, 5, 2, 0, 0, 0);     // single-point sweep
    sweep(9, 9, 1, 1, 1, 9, 0);       // single-point loop

    // start and abort together stays idle
    @(negedge clk);
    start = 1; abort = 1;
    @(negedge clk);
    start = 0; abort = 0;
    repeat (3) @(negedge clk);
    drain("start_abort");

    // asynchronous reset mid-sweep
    @(negedge clk);
    cfg_f_start = 8'd20; cfg_f_stop = 8'd100; cfg_f_step = 8'd5; cfg_dwell = 16'd1;
    cfg_p_word = 8'h5a; cfg_sel = 2'd2; cfg_amp = 2'd1; loop_mode = 0; start = 1;
    push_sweep(20, 100, 5, 1, 0, 2'd2, 2'd1, 8'h5a, 32'h4000_0000, fs);
    @(negedge clk);
    start = 0;
    repeat (4) @(negedge clk);
    #2;
    q.delete();
    rstn = 0;
    #1;
    a = actual();
    checks++;
    if (a !== '0) begin errors++; $display("FAIL async_reset act=%h exp=0", a); end
    @(negedge clk);
    rstn = 1;
    repeat (2) @(negedge clk);
    drain("async_reset");

    for (int i = 0; i < 25; i++) begin
      fs = $urandom_range(0, 255); fe = $urandom_range(0, 255);
      st = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 40);
      dw = $urandom_range(0, 3); lp = 1'($urandom);
      if (lp) ab = $urandom_range(5, 60);
      else    ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 40) : 0;
      sweep(fs, fe, st, dw, lp, ab, (ab == 0) && 1'($urandom));
    end

    mon_on = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
- Frequency-sweep sequencer that drives the control inputs of one dds instance: wave_ena, wave_sel, wave_amp, f_word and p_word.
- On a start pulse it latches a sweep configuration, then steps f_word from f_start toward f_stop by f_step.
- Each frequency is held for a programmable dwell.
- Runs once (single) or repeats (loop); abort stops it at any time.
- Sits between the register/config bus and the dds core.

Parameters:
FW, 8, frequency word width (matches dds f_word)
PW, 8, phase word width (matches dds p_word)
DW, 16, dwell counter width

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; latch config and begin sweep (ignored while busy)
abort  in  1  level/pulse; terminate sweep, return to IDLE
loop_mode  in  1  0: single sweep; 1: restart at f_start after reaching f_stop
cfg_f_start  in  FW  first frequency word
cfg_f_stop  in  FW  last frequency word
cfg_f_step  in  FW  step magnitude; 0 is treated as 1
cfg_dwell  in  DW  each frequency is held cfg_dwell+1 cycles
cfg_p_word  in  PW  phase offset, passed through while running
cfg_sel  in  2  waveform select, passed through
cfg_amp  in  2  amplitude shift, passed through
wave_ena  out  1  dds enable
wave_sel  out  2  dds waveform select
wave_amp  out  2  dds amplitude shift
f_word  out  FW  dds frequency word
p_word  out  PW  dds phase word
busy  out  1  high in RUN
done  out  1  one-cycle pulse when a single sweep completes
step_tick  out  1  one-cycle pulse on every f_word change inside a sweep

Behaviour:
- Reset:
  - All outputs are 0; state is IDLE.
  - Latched config and the dwell counter are 0.
- All outputs are registered.
- States:
  - IDLE: outputs held at 0; done may be high for exactly one cycle after completion.
  - RUN: sweeping.
- IDLE -> RUN:
  - Condition: start=1 and abort=0.
  - Latch all cfg_* and loop_mode in that cycle.
  - Direction: up if cfg_f_start <= cfg_f_stop, else down.
  - Next cycle: wave_ena=1, busy=1, f_word=f_start, p_word/sel/amp = latched values, dwell counter=0.
  - Latency start -> wave_ena = 1 cycle.
- RUN:
  - The dwell counter increments each cycle.
  - When it equals the latched dwell, the step phase runs and the counter clears.
- Step phase:
  - Compute the next word in FW+1 bits: cur+step (up) or cur-step (down).
  - If the next word passes or equals f_stop (up: next >= f_stop, including carry; down: next <= f_stop, including borrow), then f_word = f_stop.
  - If cur already equals f_stop, the sweep endpoint is reached.
  - Otherwise f_word = next.
  - step_tick pulses in the same cycle f_word changes.
  - The final f_stop value therefore gets a full dwell.
- Endpoint, single mode: next cycle RUN -> IDLE, wave_ena=0, busy=0, f_word=0, done=1 for one cycle.
- Endpoint, loop mode: f_word = f_start, step_tick=1, stay in RUN; done is not asserted.
- f_start == f_stop: the sweep is one dwell long, then endpoint.
- abort=1 in any cycle:
  - Next cycle is IDLE with all outputs 0 and no done.
  - abort has priority over start and over the endpoint in the same cycle.
- start while busy: ignored; latched config is unchanged mid-sweep.
- cfg_* changes during RUN have no effect.
- Asynchronous reset mid-sweep: immediate return to the reset values.
- The dds clears its phase when wave_ena falls; the controller does not manage phase beyond passing p_word through.

Decomposition:
- Shared package dds_pkg:
  - FW/PW default constants (8/8) shared with dds.
  - State enum (IDLE, RUN).
  - Direction typedef (UP, DOWN).
- One sub-module, dds_dwell_timer:
  - DW-bit counter with clear and a terminal-count output.
  - Instantiated once.
- Step/clamp arithmetic stays inline.

Test Plan:
- Reset, then start with f_start=10, f_stop=40, step=10, dwell=2, single:
  - wave_ena rises 1 cycle after start.
  - f_word sequence 10,20,30,40, each held 3 cycles.
  - done pulses once after 40's dwell; wave_ena=0 and f_word=0 the same cycle.
- Down sweep with clamp: f_start=50, f_stop=5, step=20, dwell=0:
  - f_word sequence 50,30,10,5, one cycle each, then done.
- Overflow clamp: f_start=200, f_stop=255, step=100:
  - f_word sequence 200,255, with no wrap to 44.
- Loop mode: f_start=0, f_stop=2, step=1, dwell=0:
  - f_word cycles 0,1,2,0,1,2…; step_tick every cycle; done never asserted.
- Abort during the 2nd dwell of a sweep:
  - Next cycle all outputs are 0 and busy=0, with no done.
  - start and abort in the same cycle keeps the block in IDLE.
- start during RUN with new cfg values: sweep continues unchanged.
- step=0 with f_start=3, f_stop=5: behaves as step 1 (3,4,5).
